gam_edge_age_mem: RTL and testbench

Per-class edge memory for the GAM learning core, successor to the static connection array: it stores node-to-node connections with ages and performs the aging and pruning sweep itself. Edges are undirected and separated by class. The learning controller issues one command per input sample, such as connect winner/second or age winner's edges, and reads back a single response. Class count, node count and age width are parameters.

---
 rtl/gam_edge_age_mem_if.sv | 30 +++
 rtl/gam_edge_age_mem.sv | 265 ++++++++++++++++++++++++++
 tb/tb_gam_edge_age_mem.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gam_edge_age_mem_if.sv
// Command/response bundle for gam_edge_age_mem.
// The learning controller drives the master side; the edge memory sits on the slave side.
interface gam_edge_age_mem_if #(
  parameter int unsigned CLS_W  = 3,
  parameter int unsigned NODE_W = 6,
  parameter int unsigned AGE_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [CLS_W-1:0]  cmd_class;
  logic [NODE_W-1:0] cmd_a;
  logic [NODE_W-1:0] cmd_b;
  logic              rsp_valid;
  logic              rsp_err;
  logic              rsp_present;
  logic [AGE_W-1:0]  rsp_age;
  logic [NODE_W-1:0] rsp_degree;
  logic [NODE_W-1:0] rsp_pruned;

  modport master (
    output cmd_valid, cmd_op, cmd_class, cmd_a, cmd_b,
    input  cmd_ready, rsp_valid, rsp_err, rsp_present, rsp_age, rsp_degree, rsp_pruned
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_class, cmd_a, cmd_b,
    output cmd_ready, rsp_valid, rsp_err, rsp_present, rsp_age, rsp_degree, rsp_pruned
  );
endinterface

// File: rtl/gam_edge_age_mem.sv
// Per-class undirected edge memory with ages for the GAM learning core.
// Single-cycle QUERY/CONNECT/DISCONNECT; AGE sweeps the winner's row one node per cycle.
// Optional feature macro: GAM_EDGE_PRUNE_EN -- when defined, edges whose age exceeds
// AGE_MAX after an AGE increment are removed and counted in rsp_pruned.
module gam_edge_age_mem #(
  parameter int unsigned CLASS_COUNT = 5,
  parameter int unsigned NODE_COUNT  = 50,
  parameter int unsigned AGE_W       = 4,
  parameter int unsigned AGE_MAX     = 6,
  parameter int unsigned CLS_W       = $clog2(CLASS_COUNT),
  parameter int unsigned NODE_W      = $clog2(NODE_COUNT + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  gam_edge_age_mem_if.slave  bus
);

`ifdef GAM_EDGE_PRUNE_EN
  localparam bit PRUNE_EN = 1'b1;
`else
  localparam bit PRUNE_EN = 1'b0;
`endif

  localparam logic [1:0] OP_QUERY      = 2'd0;
  localparam logic [1:0] OP_CONNECT    = 2'd1;
  localparam logic [1:0] OP_DISCONNECT = 2'd2;
  localparam logic [1:0] OP_AGE        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  // Full symmetric matrix: (a,b) and (b,a) are always written together.
  logic             edge_vld_q [CLASS_COUNT][NODE_COUNT+1][NODE_COUNT+1];
  logic [AGE_W-1:0] edge_age_q [CLASS_COUNT][NODE_COUNT+1][NODE_COUNT+1];

  state_e            state_q, state_d;
  logic [CLS_W-1:0]  sw_cls_q, sw_cls_d;
  logic [NODE_W-1:0] sw_a_q, sw_a_d;
  logic [NODE_W-1:0] sw_b_q, sw_b_d;
  logic [NODE_W-1:0] sw_j_q, sw_j_d;
  logic [NODE_W-1:0] deg_acc_q, deg_acc_d;
  logic [NODE_W-1:0] prn_acc_q, prn_acc_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_present_q, rsp_present_d;
  logic [AGE_W-1:0]  rsp_age_q, rsp_age_d;
  logic [NODE_W-1:0] rsp_degree_q, rsp_degree_d;
  logic [NODE_W-1:0] rsp_pruned_q, rsp_pruned_d;

  logic              cmd_ok;
  logic [CLS_W-1:0]  ix_cls;
  logic [NODE_W-1:0] ix_a;
  logic [NODE_W-1:0] ix_b;
  logic              ab_vld;
  logic [AGE_W-1:0]  ab_age;
  logic [AGE_W-1:0]  age_inc;
  logic [NODE_W-1:0] row_cnt;
  logic              wr_en;
  logic              wr_vld;
  logic [AGE_W-1:0]  wr_age;

  // Command legality: nodes 1..NODE_COUNT, distinct, class in range.
  always_comb begin
    cmd_ok = (bus.cmd_a != '0) && (bus.cmd_b != '0) &&
             (32'(bus.cmd_a) <= NODE_COUNT) && (32'(bus.cmd_b) <= NODE_COUNT) &&
             (bus.cmd_a != bus.cmd_b) && (32'(bus.cmd_class) < CLASS_COUNT);
  end

  // Shared read/write address: sweep row (a,j) while sweeping, else the clamped command pair.
  always_comb begin
    ix_cls = '0;
    ix_a   = '0;
    ix_b   = '0;
    if (state_q == ST_SWEEP) begin
      ix_cls = sw_cls_q;
      ix_a   = sw_a_q;
      ix_b   = sw_j_q;
    end else if (cmd_ok) begin
      ix_cls = bus.cmd_class;
      ix_a   = bus.cmd_a;
      ix_b   = bus.cmd_b;
    end
  end

  // Read the addressed edge and its saturating next age.
  always_comb begin
    ab_vld  = edge_vld_q[ix_cls][ix_a][ix_b];
    ab_age  = edge_age_q[ix_cls][ix_a][ix_b];
    age_inc = (ab_age == {AGE_W{1'b1}}) ? ab_age : ab_age + AGE_W'(1);
  end

  // Degree of node a before the current single-cycle op.
  always_comb begin
    row_cnt = '0;
    for (int unsigned j = 1; j <= NODE_COUNT; j++) begin
      row_cnt = row_cnt + NODE_W'(edge_vld_q[ix_cls][ix_a][j]);
    end
  end

  // Next-state, edge write port and response computation.
  always_comb begin
    state_d       = state_q;
    sw_cls_d      = sw_cls_q;
    sw_a_d        = sw_a_q;
    sw_b_d        = sw_b_q;
    sw_j_d        = sw_j_q;
    deg_acc_d     = deg_acc_q;
    prn_acc_d     = prn_acc_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err_q;
    rsp_present_d = rsp_present_q;
    rsp_age_d     = rsp_age_q;
    rsp_degree_d  = rsp_degree_q;
    rsp_pruned_d  = rsp_pruned_q;
    wr_en         = 1'b0;
    wr_vld        = 1'b0;
    wr_age        = '0;

    unique case (state_q)
      ST_SWEEP: begin
        if (sw_j_q == sw_b_q) begin
          wr_en     = 1'b1;
          wr_vld    = 1'b1;
          deg_acc_d = deg_acc_q + NODE_W'(1);
        end else if ((sw_j_q != sw_a_q) && ab_vld) begin
          wr_en = 1'b1;
          if (PRUNE_EN && (32'(age_inc) > AGE_MAX)) begin
            prn_acc_d = prn_acc_q + NODE_W'(1);
          end else begin
            wr_vld    = 1'b1;
            wr_age    = age_inc;
            deg_acc_d = deg_acc_q + NODE_W'(1);
          end
        end
        if (32'(sw_j_q) == NODE_COUNT) begin
          state_d       = ST_RESP;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b0;
          rsp_present_d = 1'b1;
          rsp_age_d     = '0;
          rsp_degree_d  = deg_acc_d;
          rsp_pruned_d  = prn_acc_d;
        end else begin
          sw_j_d = sw_j_q + NODE_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (bus.cmd_valid) begin
          rsp_valid_d  = 1'b1;
          rsp_err_d    = 1'b0;
          rsp_pruned_d = '0;
          if (!cmd_ok) begin
            rsp_err_d     = 1'b1;
            rsp_present_d = 1'b0;
            rsp_age_d     = '0;
            rsp_degree_d  = '0;
          end else begin
            unique case (bus.cmd_op)
              OP_QUERY: begin
                rsp_present_d = ab_vld;
                rsp_age_d     = ab_age;
                rsp_degree_d  = row_cnt;
              end
              OP_CONNECT: begin
                wr_en         = 1'b1;
                wr_vld        = 1'b1;
                rsp_present_d = 1'b1;
                rsp_age_d     = '0;
                rsp_degree_d  = ab_vld ? row_cnt : row_cnt + NODE_W'(1);
              end
              OP_DISCONNECT: begin
                wr_en         = 1'b1;
                rsp_present_d = 1'b0;
                rsp_age_d     = '0;
                rsp_degree_d  = ab_vld ? row_cnt - NODE_W'(1) : row_cnt;
              end
              OP_AGE: begin
                rsp_valid_d  = 1'b0;
                rsp_pruned_d = rsp_pruned_q;
                state_d      = ST_SWEEP;
                sw_cls_d     = bus.cmd_class;
                sw_a_d       = bus.cmd_a;
                sw_b_d       = bus.cmd_b;
                sw_j_d       = NODE_W'(1);
                deg_acc_d    = '0;
                prn_acc_d    = '0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase

    cmd_ready_d = (state_d != ST_SWEEP);
  end

  // Control, sweep context and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sw_cls_q      <= '0;
      sw_a_q        <= '0;
      sw_b_q        <= '0;
      sw_j_q        <= '0;
      deg_acc_q     <= '0;
      prn_acc_q     <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_present_q <= 1'b0;
      rsp_age_q     <= '0;
      rsp_degree_q  <= '0;
      rsp_pruned_q  <= '0;
    end else begin
      state_q       <= state_d;
      sw_cls_q      <= sw_cls_d;
      sw_a_q        <= sw_a_d;
      sw_b_q        <= sw_b_d;
      sw_j_q        <= sw_j_d;
      deg_acc_q     <= deg_acc_d;
      prn_acc_q     <= prn_acc_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_present_q <= rsp_present_d;
      rsp_age_q     <= rsp_age_d;
      rsp_degree_q  <= rsp_degree_d;
      rsp_pruned_q  <= rsp_pruned_d;
    end
  end

  // Edge storage: reset clears every edge, writes update both orientations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CLASS_COUNT; c++) begin
        for (int unsigned a = 0; a <= NODE_COUNT; a++) begin
          for (int unsigned b = 0; b <= NODE_COUNT; b++) begin
            edge_vld_q[c][a][b] <= 1'b0;
            edge_age_q[c][a][b] <= '0;
          end
        end
      end
    end else if (wr_en) begin
      edge_vld_q[ix_cls][ix_a][ix_b] <= wr_vld;
      edge_vld_q[ix_cls][ix_b][ix_a] <= wr_vld;
      edge_age_q[ix_cls][ix_a][ix_b] <= wr_age;
      edge_age_q[ix_cls][ix_b][ix_a] <= wr_age;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_present = rsp_present_q;
  assign bus.rsp_age     = rsp_age_q;
  assign bus.rsp_degree  = rsp_degree_q;
  assign bus.rsp_pruned  = rsp_pruned_q;

endmodule

// File: tb/tb_gam_edge_age_mem.sv
// Self-checking bench for gam_edge_age_mem: directed steps plus random commands
// compared against an edge-matrix reference model. Honours GAM_EDGE_PRUNE_EN.
module tb_gam_edge_age_mem;
  localparam int unsigned CLASS_COUNT = 5;
  localparam int unsigned NODE_COUNT  = 50;
  localparam int unsigned AGE_W       = 4;
  localparam int unsigned AGE_MAX     = 6;
  localparam int unsigned CLS_W       = $clog2(CLASS_COUNT);
  localparam int unsigned NODE_W      = $clog2(NODE_COUNT + 1);
  localparam int          AGE_SAT     = (1 << AGE_W) - 1;
`ifdef GAM_EDGE_PRUNE_EN
  localparam bit PRUNE = 1'b1;
`else
  localparam bit PRUNE = 1'b0;
`endif

  typedef struct {
    logic [31:0] err;
    logic [31:0] present;
    logic [31:0] age;
    logic [31:0] degree;
    logic [31:0] pruned;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bit m_vld [CLASS_COUNT][NODE_COUNT+1][NODE_COUNT+1];
  int m_age [CLASS_COUNT][NODE_COUNT+1][NODE_COUNT+1];

  always #5 clk = ~clk;

  gam_edge_age_mem_if #(.CLS_W(CLS_W), .NODE_W(NODE_W), .AGE_W(AGE_W)) bus ();

  gam_edge_age_mem #(
    .CLASS_COUNT(CLASS_COUNT), .NODE_COUNT(NODE_COUNT), .AGE_W(AGE_W),
    .AGE_MAX(AGE_MAX), .CLS_W(CLS_W), .NODE_W(NODE_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input rsp_t got, input rsp_t exp);
    check($sformatf("%s.err", tag),     got.err,     exp.err);
    check($sformatf("%s.present", tag), got.present, exp.present);
    check($sformatf("%s.age", tag),     got.age,     exp.age);
    check($sformatf("%s.degree", tag),  got.degree,  exp.degree);
    check($sformatf("%s.pruned", tag),  got.pruned,  exp.pruned);
  endtask

  function automatic void model_clear();
    for (int c = 0; c < CLASS_COUNT; c++)
      for (int a = 0; a <= NODE_COUNT; a++)
        for (int b = 0; b <= NODE_COUNT; b++) begin
          m_vld[c][a][b] = 1'b0;
          m_age[c][a][b] = 0;
        end
  endfunction

  function automatic bit model_valid(input int c, input int a, input int b);
    return !(a < 1 || b < 1 || a > NODE_COUNT || b > NODE_COUNT || a == b ||
             c < 0 || c >= CLASS_COUNT);
  endfunction

  function automatic void model_set(input int c, input int a, input int b, input bit v, input int g);
    m_vld[c][a][b] = v; m_vld[c][b][a] = v;
    m_age[c][a][b] = g; m_age[c][b][a] = g;
  endfunction

  // Apply one command to the reference matrix and return the response it implies.
  function automatic rsp_t model_exec(input int op, input int c, input int a, input int b);
    rsp_t r;
    int   n;
    r = '{err: 0, present: 0, age: 0, degree: 0, pruned: 0};
    if (!model_valid(c, a, b)) begin
      r.err = 1;
      return r;
    end
    case (op)
      1: model_set(c, a, b, 1'b1, 0);
      2: model_set(c, a, b, 1'b0, 0);
      3: begin
        for (int j = 1; j <= NODE_COUNT; j++) begin
          if (j == b) model_set(c, a, j, 1'b1, 0);
          else if (j != a && m_vld[c][a][j]) begin
            n = m_age[c][a][j] + 1;
            if (n > AGE_SAT) n = AGE_SAT;
            if (PRUNE && n > AGE_MAX) begin
              model_set(c, a, j, 1'b0, 0);
              r.pruned = r.pruned + 1;
            end else model_set(c, a, j, 1'b1, n);
          end
        end
      end
      default: ;
    endcase
    r.present = 32'(m_vld[c][a][b]);
    r.age     = 32'(m_age[c][a][b]);
    for (int j = 1; j <= NODE_COUNT; j++) r.degree = r.degree + 32'(m_vld[c][a][j]);
    return r;
  endfunction

  function automatic rsp_t sample_rsp();
    rsp_t r;
    r.err     = 32'(bus.rsp_err);
    r.present = 32'(bus.rsp_present);
    r.age     = 32'(bus.rsp_age);
    r.degree  = 32'(bus.rsp_degree);
    r.pruned  = 32'(bus.rsp_pruned);
    return r;
  endfunction

  task automatic drive(input int op, input int c, input int a, input int b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'(op);
    bus.cmd_class = CLS_W'(c);
    bus.cmd_a     = NODE_W'(a);
    bus.cmd_b     = NODE_W'(b);
  endtask

  // Issue one command and wait (bounded) for its response pulse.
  task automatic run_cmd(input int op, input int c, input int a, input int b,
                         output rsp_t got, output int lat, output int rdy_low);
    @(negedge clk);
    drive(op, c, a, b);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    lat = 1;
    rdy_low = 0;
    while (!bus.rsp_valid && lat < 200) begin
      if (!bus.cmd_ready) rdy_low++;
      @(posedge clk); #1;
      lat++;
    end
    got = sample_rsp();
  endtask

  task automatic do_cmd(input string tag, input int op, input int c, input int a, input int b,
                        output rsp_t got);
    rsp_t exp;
    int   lat, rdy_low;
    bit   is_age;
    is_age = (op == 3) && model_valid(c, a, b);
    exp = model_exec(op, c, a, b);
    run_cmd(op, c, a, b, got, lat, rdy_low);
    check($sformatf("%s.lat", tag), 32'(lat), is_age ? 32'(NODE_COUNT + 1) : 32'd1);
    if (is_age) check($sformatf("%s.rdy_low", tag), 32'(rdy_low), 32'(NODE_COUNT));
    check_rsp(tag, got, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t got, exp;
    int   hits;
    model_clear();
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0; bus.cmd_class = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_rsp("rst", sample_rsp(), '{err: 0, present: 0, age: 0, degree: 0, pruned: 0});

    // Empty memory query, then the response must be a one-cycle pulse
    do_cmd("q_empty", 0, 0, 1, 2, got);
    @(posedge clk); #1;
    check("q_empty.pulse", 32'(bus.rsp_valid), 32'd0);

    // Undirected connect, class isolation
    do_cmd("conn_c2", 1, 2, 3, 7, got);
    do_cmd("q_c2_rev", 0, 2, 7, 3, got);
    check("q_c2_rev.present_k", got.present, 32'd1);
    check("q_c2_rev.degree_k", got.degree, 32'd1);
    do_cmd("q_c1", 0, 1, 7, 3, got);
    check("q_c1.present_k", got.present, 32'd0);

    // Aging sequence on winner 5, second 6, neighbour 9
    do_cmd("conn56", 1, 0, 5, 6, got);
    do_cmd("conn59", 1, 0, 5, 9, got);
    for (int k = 1; k <= 7; k++) begin
      do_cmd($sformatf("age%0d", k), 3, 0, 5, 6, got);
      if (k <= 6) check($sformatf("age%0d.degree_k", k), got.degree, 32'd2);
      else begin
        check("age7.degree_k", got.degree, PRUNE ? 32'd1 : 32'd2);
        check("age7.pruned_k", got.pruned, PRUNE ? 32'd1 : 32'd0);
      end
      do_cmd($sformatf("q59_%0d", k), 0, 0, 5, 9, got);
      if (k <= 6) check($sformatf("q59_%0d.age_k", k), got.age, 32'(k));
      else begin
        check("q59_7.present_k", got.present, PRUNE ? 32'd0 : 32'd1);
        check("q59_7.age_k", got.age, PRUNE ? 32'd0 : 32'd7);
      end
    end

    // Invalid commands leave state untouched
    do_cmd("inv_a0", 1, 0, 0, 3, got);
    check("inv_a0.err_k", got.err, 32'd1);
    do_cmd("inv_aeqb", 1, 0, 4, 4, got);
    do_cmd("inv_a51", 1, 0, 51, 2, got);
    do_cmd("inv_cls5", 1, 5, 1, 2, got);
    do_cmd("inv_age", 3, 0, 0, 6, got);
    do_cmd("inv_follow", 0, 0, 5, 6, got);
    check("inv_follow.present_k", got.present, 32'd1);

    // Random commands against the model
    for (int i = 0; i < 80; i++) begin
      int op, c, a, b;
      op = int'($urandom_range(0, 3));
      if (op == 3 && $urandom_range(0, 2) != 0) op = 1;
      c  = ($urandom_range(0, 9) == 0) ? 5 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
      a  = int'($urandom_range(0, 8));
      b  = int'($urandom_range(0, 8));
      if ($urandom_range(0, 19) == 0) a = 51 + int'($urandom_range(0, 12));
      do_cmd($sformatf("rnd%0d", i), op, c, a, b, got);
    end

    // Back-to-back CONNECT, DISCONNECT, QUERY on (1,2)
    @(negedge clk);
    drive(1, 0, 1, 2);
    exp = model_exec(1, 0, 1, 2);
    @(posedge clk); #1;
    check("b2b_conn.valid", 32'(bus.rsp_valid), 32'd1);
    check_rsp("b2b_conn", sample_rsp(), exp);
    drive(2, 0, 1, 2);
    exp = model_exec(2, 0, 1, 2);
    @(posedge clk); #1;
    check("b2b_disc.valid", 32'(bus.rsp_valid), 32'd1);
    check_rsp("b2b_disc", sample_rsp(), exp);
    drive(0, 0, 1, 2);
    exp = model_exec(0, 0, 1, 2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    check("b2b_q.valid", 32'(bus.rsp_valid), 32'd1);
    check_rsp("b2b_q", sample_rsp(), exp);
    check("b2b_q.present_k", 32'(bus.rsp_present), 32'd0);
    @(posedge clk); #1;
    check("b2b.idle", 32'(bus.rsp_valid), 32'd0);

    // Reset in the middle of an AGE sweep
    do_cmd("pre_rst1", 1, 3, 1, 2, got);
    do_cmd("pre_rst2", 1, 3, 2, 4, got);
    do_cmd("pre_rst3", 1, 4, 7, 8, got);
    @(negedge clk);
    drive(3, 3, 1, 2);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    hits = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) hits++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst.ready", 32'(bus.cmd_ready), 32'd1);
    check("mid_rst.valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (NODE_COUNT + 5) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) hits++;
    end
    check("mid_rst.no_rsp", 32'(hits), 32'd0);
    check("mid_rst.ready_after", 32'(bus.cmd_ready), 32'd1);
    model_clear();
    do_cmd("post_rst1", 0, 3, 1, 2, got);
    check("post_rst1.present_k", got.present, 32'd0);
    do_cmd("post_rst2", 0, 3, 4, 2, got);
    do_cmd("post_rst3", 0, 4, 8, 7, got);
    do_cmd("post_rst4", 0, 0, 5, 6, got);
    check("post_rst4.present_k", got.present, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
